// File: rtl/dtw_pkg.sv
// Shared definitions for the subsequence-DTW row engine: FSM state encoding,
// stream constants and the cost arithmetic helpers.
package dtw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_REF,
        ST_ROW,
        ST_ROW_WAIT,
        ST_EMIT_COST,
        ST_EMIT_IDX
    } state_e;

    // tuser value marking a reference beat on the input stream
    localparam logic TUSER_REF = 1'b1;

    // Control register bit that drives i_enable
    localparam int CTRL_ENABLE_BIT = 0;

    // Unsigned add clamped to 2^w-1 (operands must already fit in w bits)
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [63:0] max_v;
        logic [63:0] sum;
        max_v = (64'd1 << w) - 64'd1;
        sum   = a + b;
        return (sum > max_v) ? max_v : sum;
    endfunction

    // Absolute difference of two unsigned samples
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sdtw_row_engine_if.sv
// AXI-stream style handshake bundle used for both the sample input and the
// result output of the row engine.
interface sdtw_row_engine_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tlast, output tuser, output tdata, input tready);
    modport slave  (input tvalid, input tlast, input tuser, input tdata, output tready);
endinterface

// File: rtl/dtw_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a
// single cycle of read latency. Contents are not initialised.
module dtw_ram #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Registered write and registered read
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/sdtw_row_engine.sv
// Streaming subsequence-DTW stage: loads a reference squiggle, computes one
// DTW row per query sample in place in a row memory, and emits the minimum
// cost of the final row and its column index as a two-beat result.
module sdtw_row_engine
    import dtw_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int COST_WIDTH      = 32,
    parameter int MAX_REF_LEN     = 1024,
    parameter int REF_ADDR_WIDTH  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    sdtw_row_engine_if.slave        axis_in,
    sdtw_row_engine_if.master       axis_out,
    output logic [REF_ADDR_WIDTH:0] o_ref_len,
    output logic                    o_ref_loaded,
    output logic                    o_busy,
    output logic                    o_err
);
    localparam int LEN_W = REF_ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_REF_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    // control state (reset)
    state_e                     state_q, state_d;
    logic [LEN_W-1:0]           cnt_q, cnt_d;
    logic [LEN_W-1:0]           ref_len_q, ref_len_d;
    logic                       ref_loaded_q, ref_loaded_d;
    logic                       err_q, err_d;
    logic                       vld_p1_q, vld_p1_d;
    logic                       out_tvalid_q, out_tvalid_d;
    logic                       out_tlast_q, out_tlast_d;
    logic [AXIS_DATA_WIDTH-1:0] out_tdata_q, out_tdata_d;

    // datapath state (no reset)
    logic [SAMPLE_WIDTH-1:0]    q_q, q_d;
    logic                       last_q, last_d;
    logic                       first_row_q, first_row_d;
    logic [REF_ADDR_WIDTH-1:0]  j_p1_q, j_p1_d;
    logic [COST_WIDTH-1:0]      left_q, left_d;
    logic [COST_WIDTH-1:0]      diag_q, diag_d;
    logic [COST_WIDTH-1:0]      min_cost_q, min_cost_d;
    logic [REF_ADDR_WIDTH-1:0]  min_idx_q, min_idx_d;

    logic                       in_rdy;
    logic                       in_hs;
    logic                       ref_we;
    logic [REF_ADDR_WIDTH-1:0]  ref_waddr;
    logic [REF_ADDR_WIDTH-1:0]  rd_addr;
    logic [SAMPLE_WIDTH-1:0]    in_sample;
    logic [SAMPLE_WIDTH-1:0]    ref_rd;
    logic [COST_WIDTH-1:0]      row_rd;
    logic [COST_WIDTH-1:0]      cost_p1;
    logic [COST_WIDTH-1:0]      best_p1;
    logic [COST_WIDTH-1:0]      cell_p1;
    logic                       unused_hi;

    assign in_sample = axis_in.tdata[SAMPLE_WIDTH-1:0];
    assign unused_hi = ^axis_in.tdata[AXIS_DATA_WIDTH-1:SAMPLE_WIDTH];
    assign rd_addr   = cnt_q[REF_ADDR_WIDTH-1:0];
    assign ref_waddr = (state_q == ST_IDLE) ? '0 : cnt_q[REF_ADDR_WIDTH-1:0];

    dtw_ram #(.WIDTH(SAMPLE_WIDTH), .DEPTH(MAX_REF_LEN), .ADDR_W(REF_ADDR_WIDTH)) u_ref_ram (
        .clk   (clk),
        .we    (ref_we),
        .waddr (ref_waddr),
        .wdata (in_sample),
        .raddr (rd_addr),
        .rdata (ref_rd)
    );

    // The row memory holds D[i-1][*] and is overwritten cell by cell with D[i][*]
    dtw_ram #(.WIDTH(COST_WIDTH), .DEPTH(MAX_REF_LEN), .ADDR_W(REF_ADDR_WIDTH)) u_row_ram (
        .clk   (clk),
        .we    (vld_p1_q),
        .waddr (j_p1_q),
        .wdata (cell_p1),
        .raddr (rd_addr),
        .rdata (row_rd)
    );

    // Input is accepted in IDLE only when enabled; tready is forced low under reset
    always_comb begin
        in_rdy = 1'b0;
        case (state_q)
            ST_IDLE:     in_rdy = i_enable && !rst;
            ST_LOAD_REF: in_rdy = !rst;
            ST_ROW_WAIT: in_rdy = !rst;
            default:     in_rdy = 1'b0;
        endcase
        in_hs = in_rdy && axis_in.tvalid;
    end

    // ---- stage p1: RAM outputs for column j_p1 are valid; form D[i][j] ----
    // The left neighbour is the previous cell's result; the diagonal is the
    // previous cell's old row value.
    always_comb begin
        cost_p1 = COST_WIDTH'(abs_diff(32'(q_q), 32'(ref_rd)));
        best_p1 = (row_rd < left_q) ? row_rd : left_q;
        if (diag_q < best_p1) begin
            best_p1 = diag_q;
        end
        if (first_row_q) begin
            cell_p1 = cost_p1;
        end else if (j_p1_q == '0) begin
            cell_p1 = COST_WIDTH'(sat_add(64'(cost_p1), 64'(row_rd), COST_WIDTH));
        end else begin
            cell_p1 = COST_WIDTH'(sat_add(64'(cost_p1), 64'(best_p1), COST_WIDTH));
        end

        left_d     = vld_p1_q ? cell_p1 : left_q;
        diag_d     = vld_p1_q ? row_rd  : diag_q;
        min_cost_d = min_cost_q;
        min_idx_d  = min_idx_q;
        // strict less-than keeps the lowest column on ties
        if (vld_p1_q && last_q && ((j_p1_q == '0) || (cell_p1 < min_cost_q))) begin
            min_cost_d = cell_p1;
            min_idx_d  = j_p1_q;
        end
    end

    // Next-state logic for the session FSM, reference loading and result emission
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ref_len_d    = ref_len_q;
        ref_loaded_d = ref_loaded_q;
        err_d        = err_q;
        vld_p1_d     = 1'b0;
        j_p1_d       = j_p1_q;
        out_tvalid_d = out_tvalid_q;
        out_tlast_d  = out_tlast_q;
        out_tdata_d  = out_tdata_q;
        q_d          = q_q;
        last_d       = last_q;
        first_row_d  = first_row_q;
        ref_we       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    if (axis_in.tuser == TUSER_REF) begin
                        ref_we       = 1'b1;
                        ref_loaded_d = 1'b0;
                        err_d        = 1'b0;
                        if (axis_in.tlast) begin
                            ref_len_d    = LEN_ONE;
                            ref_loaded_d = 1'b1;
                        end else begin
                            cnt_d   = LEN_ONE;
                            state_d = ST_LOAD_REF;
                        end
                    end else if (!ref_loaded_q) begin
                        err_d = 1'b1;
                    end else begin
                        q_d         = in_sample;
                        last_d      = axis_in.tlast;
                        first_row_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_ROW;
                    end
                end
            end
            ST_LOAD_REF: begin
                if (in_hs) begin
                    if (axis_in.tuser == TUSER_REF) begin
                        if (cnt_q < LEN_MAX) begin
                            ref_we = 1'b1;
                            cnt_d  = cnt_q + LEN_ONE;
                        end else begin
                            err_d = 1'b1;
                        end
                        if (axis_in.tlast) begin
                            ref_len_d    = (cnt_q < LEN_MAX) ? (cnt_q + LEN_ONE) : cnt_q;
                            ref_loaded_d = 1'b1;
                            state_d      = ST_IDLE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ROW: begin
                // ---- stage p0: issue reads for column cnt; two drain cycles follow ----
                vld_p1_d = (cnt_q < ref_len_q);
                j_p1_d   = cnt_q[REF_ADDR_WIDTH-1:0];
                cnt_d    = cnt_q + LEN_ONE;
                if (cnt_q == (ref_len_q + LEN_ONE)) begin
                    if (last_q) begin
                        out_tvalid_d = 1'b1;
                        out_tlast_d  = 1'b0;
                        out_tdata_d  = AXIS_DATA_WIDTH'(min_cost_q);
                        state_d      = ST_EMIT_COST;
                    end else begin
                        first_row_d = 1'b0;
                        state_d     = ST_ROW_WAIT;
                    end
                end
            end
            ST_ROW_WAIT: begin
                if (in_hs) begin
                    if (axis_in.tuser == TUSER_REF) begin
                        err_d = 1'b1;
                    end else begin
                        q_d     = in_sample;
                        last_d  = axis_in.tlast;
                        cnt_d   = '0;
                        state_d = ST_ROW;
                    end
                end
            end
            ST_EMIT_COST: begin
                if (axis_out.tready) begin
                    out_tdata_d = AXIS_DATA_WIDTH'(min_idx_q);
                    out_tlast_d = 1'b1;
                    state_d     = ST_EMIT_IDX;
                end
            end
            ST_EMIT_IDX: begin
                if (axis_out.tready) begin
                    out_tvalid_d = 1'b0;
                    out_tlast_d  = 1'b0;
                    out_tdata_d  = '0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ref_len_q    <= '0;
            ref_loaded_q <= 1'b0;
            err_q        <= 1'b0;
            vld_p1_q     <= 1'b0;
            out_tvalid_q <= 1'b0;
            out_tlast_q  <= 1'b0;
            out_tdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ref_len_q    <= ref_len_d;
            ref_loaded_q <= ref_loaded_d;
            err_q        <= err_d;
            vld_p1_q     <= vld_p1_d;
            out_tvalid_q <= out_tvalid_d;
            out_tlast_q  <= out_tlast_d;
            out_tdata_q  <= out_tdata_d;
        end
    end

    // Datapath registers; always written before use within a session
    always_ff @(posedge clk) begin
        q_q         <= q_d;
        last_q      <= last_d;
        first_row_q <= first_row_d;
        j_p1_q      <= j_p1_d;
        left_q      <= left_d;
        diag_q      <= diag_d;
        min_cost_q  <= min_cost_d;
        min_idx_q   <= min_idx_d;
    end

    assign axis_in.tready  = in_rdy;
    assign axis_out.tvalid = out_tvalid_q;
    assign axis_out.tlast  = out_tlast_q;
    assign axis_out.tdata  = out_tdata_q;
    assign axis_out.tuser  = 1'b0;
    assign o_ref_len       = ref_len_q;
    assign o_ref_loaded    = ref_loaded_q;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_err           = err_q;
endmodule

// File: tb/tb_sdtw_row_engine.sv
// Bench for sdtw_row_engine: a 32-bit-cost instance and a 16-bit-cost instance
// receive identical stimulus; a DTW model computes the expected results.
module tb_sdtw_row_engine;
    localparam int MAXL = 1024;

    logic clk;
    logic rst;
    logic s_en;
    logic s_tvalid, s_tuser, s_tlast, s_out_rdy;
    logic [31:0] s_tdata;

    sdtw_row_engine_if #(.DATA_W(32)) in_a ();
    sdtw_row_engine_if #(.DATA_W(32)) out_a ();
    sdtw_row_engine_if #(.DATA_W(32)) in_b ();
    sdtw_row_engine_if #(.DATA_W(32)) out_b ();

    logic [10:0] len_a, len_b;
    logic loaded_a, loaded_b, busy_a, busy_b, err_a, err_b;

    assign in_a.tvalid = s_tvalid;
    assign in_a.tuser  = s_tuser;
    assign in_a.tlast  = s_tlast;
    assign in_a.tdata  = s_tdata;
    assign in_b.tvalid = s_tvalid;
    assign in_b.tuser  = s_tuser;
    assign in_b.tlast  = s_tlast;
    assign in_b.tdata  = s_tdata;
    assign out_a.tready = s_out_rdy;
    assign out_b.tready = s_out_rdy;

    sdtw_row_engine dut_a (
        .clk(clk), .rst(rst), .i_enable(s_en),
        .axis_in(in_a), .axis_out(out_a),
        .o_ref_len(len_a), .o_ref_loaded(loaded_a), .o_busy(busy_a), .o_err(err_a)
    );

    sdtw_row_engine #(.COST_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .i_enable(s_en),
        .axis_in(in_b), .axis_out(out_b),
        .o_ref_len(len_b), .o_ref_loaded(loaded_b), .o_busy(busy_b), .o_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        last;
        logic [31:0] da;
        logic [31:0] db;
    } exp_t;

    int   m_ref[$];
    int   m_q[$];
    bit   m_loaded, m_err, m_in_load, m_in_sess;
    int   m_len;
    exp_t exp_q[$];

    // Full subsequence-DTW over m_ref x m_q with costs clamped to w bits
    function automatic void model_dtw(input int w, output longint best, output int at);
        longint maxv, c, m, d;
        longint prev[$];
        longint cur[$];
        maxv = (longint'(1) << w) - 1;
        for (int i = 0; i < m_q.size(); i++) begin
            cur.delete();
            for (int j = 0; j < m_ref.size(); j++) begin
                c = (m_q[i] > m_ref[j]) ? longint'(m_q[i] - m_ref[j]) : longint'(m_ref[j] - m_q[i]);
                if (i == 0) d = c;
                else if (j == 0) d = c + prev[0];
                else begin
                    m = prev[j];
                    if (cur[j-1] < m) m = cur[j-1];
                    if (prev[j-1] < m) m = prev[j-1];
                    d = c + m;
                end
                if (d > maxv) d = maxv;
                cur.push_back(d);
            end
            prev = cur;
        end
        best = prev[0];
        at = 0;
        for (int j = 1; j < prev.size(); j++) begin
            if (prev[j] < best) begin
                best = prev[j];
                at = j;
            end
        end
    endfunction

    task automatic push_result();
        longint ca, cb;
        int ia, ib;
        exp_t e;
        model_dtw(32, ca, ia);
        model_dtw(16, cb, ib);
        e.last = 1'b0; e.da = 32'(ca); e.db = 32'(cb);
        exp_q.push_back(e);
        e.last = 1'b1; e.da = 32'(ia); e.db = 32'(ib);
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_ref.delete(); m_q.delete(); exp_q.delete();
        m_loaded = 0; m_err = 0; m_in_load = 0; m_in_sess = 0; m_len = 0;
    endtask

    task automatic model_apply(input logic u, input logic l, input int d);
        if (m_in_load) begin
            if (u) begin
                if (m_ref.size() < MAXL) m_ref.push_back(d);
                else m_err = 1;
                if (l) begin m_in_load = 0; m_loaded = 1; m_len = m_ref.size(); end
            end else m_err = 1;
        end else if (m_in_sess) begin
            if (u) m_err = 1;
            else begin
                m_q.push_back(d);
                if (l) begin push_result(); m_in_sess = 0; end
            end
        end else begin
            if (u) begin
                m_ref.delete(); m_ref.push_back(d);
                m_loaded = 0; m_err = 0;
                if (l) begin m_loaded = 1; m_len = 1; end
                else m_in_load = 1;
            end else if (!m_loaded) m_err = 1;
            else begin
                m_q.delete(); m_q.push_back(d);
                if (l) push_result();
                else m_in_sess = 1;
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic        pv, prdy, ptl;
    logic [31:0] ptd_a, ptd_b;
    logic [31:0] cap_cost, cap_idx, cap_cost_b, cap_idx_b;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pv <= 1'b0;
        end else begin
            chk("err_a", err_a, m_err);
            chk("err_b", err_b, m_err);
            chk("loaded_a", loaded_a, m_loaded);
            chk("loaded_b", loaded_b, m_loaded);
            if (m_loaded) begin
                chk("ref_len_a", len_a, m_len);
                chk("ref_len_b", len_b, m_len);
            end
            chk("tvalid_b", out_b.tvalid, out_a.tvalid === 1'b1 ? 1 : 0);
            if (pv && !prdy) begin
                chk("hold_tvalid", out_a.tvalid, 1);
                chk("hold_tdata_a", out_a.tdata, ptd_a);
                chk("hold_tdata_b", out_b.tdata, ptd_b);
                chk("hold_tlast", out_a.tlast, ptl);
            end
            if (out_a.tvalid && s_out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", out_a.tvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_tlast_a", out_a.tlast, e.last);
                    chk("beat_tlast_b", out_b.tlast, e.last);
                    chk("beat_tdata_a", out_a.tdata, e.da);
                    chk("beat_tdata_b", out_b.tdata, e.db);
                    if (e.last) begin cap_idx <= out_a.tdata; cap_idx_b <= out_b.tdata; end
                    else begin cap_cost <= out_a.tdata; cap_cost_b <= out_b.tdata; end
                end
            end
            pv   <= out_a.tvalid;
            prdy <= s_out_rdy;
            ptl  <= out_a.tlast;
            ptd_a <= out_a.tdata;
            ptd_b <= out_b.tdata;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic u, input logic l, input int d);
        bit ok;
        s_tuser = u; s_tlast = l; s_tdata = 32'(d); s_tvalid = 1'b1;
        ok = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (in_a.tready) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        if (ok) model_apply(u, l, d);
        s_tvalid = 1'b0;
    endtask

    task automatic cycles_until_valid(output int n);
        n = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (out_a.tvalid) break;
            n++;
        end
    endtask

    task automatic cycles_until_ready(output int n);
        n = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (k == 0) chk("busy_in_row", busy_a, 1);
            if (in_a.tready) break;
            n++;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk); #1;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tready_a"}, in_a.tready, 0);
        chk({tag, "_tready_b"}, in_b.tready, 0);
        chk({tag, "_tvalid"}, out_a.tvalid, 0);
        chk({tag, "_tlast"}, out_a.tlast, 0);
        chk({tag, "_tdata"}, out_a.tdata, 0);
        chk({tag, "_ref_len"}, len_a, 0);
        chk({tag, "_loaded"}, loaded_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_err"}, err_a, 0);
        chk({tag, "_err_b"}, err_b, 0);
    endtask

    task automatic load_ref4();
        send(1, 0, 10); send(1, 0, 20); send(1, 0, 30); send(1, 1, 40);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        longint c;
        int i;
        int n;
        rst = 1'b1; s_en = 1'b1;
        s_tvalid = 0; s_tuser = 0; s_tlast = 0; s_tdata = 0; s_out_rdy = 1'b1;
        pv = 0; prdy = 0; ptl = 0; ptd_a = 0; ptd_b = 0;
        cap_cost = 0; cap_idx = 0; cap_cost_b = 0; cap_idx_b = 0;

        // Hand-computed pins for the model
        m_ref = '{10, 20, 30, 40}; m_q = '{20, 30};
        model_dtw(32, c, i); chk("pin_cost_a", c, 0); chk("pin_idx_a", i, 2);
        m_q = '{25};
        model_dtw(32, c, i); chk("pin_cost_b", c, 5); chk("pin_idx_b", i, 1);
        m_ref = '{0}; m_q = '{65535, 65535};
        model_dtw(16, c, i); chk("pin_sat16", c, 65535);
        model_dtw(32, c, i); chk("pin_nosat32", c, 131070);
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic session: two query rows
        load_ref4();
        chk("t1_ref_len", len_a, 4);
        chk("t1_loaded", loaded_a, 1);
        send(0, 0, 20);
        cycles_until_ready(n);
        chk("t1_row_cycles", n, 6);
        @(posedge clk); #1;
        send(0, 1, 30);
        cycles_until_valid(n);
        chk("t1_last_row_cycles", n, 6);
        drain();
        chk("t1_cost", cap_cost, 0);
        chk("t1_idx", cap_idx, 2);
        chk("t1_err", err_a, 0);

        // Single-sample query with a tie
        send(0, 1, 25);
        cycles_until_valid(n);
        chk("t2_row_cycles", n, 6);
        drain();
        chk("t2_cost", cap_cost, 5);
        chk("t2_idx", cap_idx, 1);

        // Enable low blocks acceptance in IDLE
        s_en = 1'b0; s_tvalid = 1'b1; s_tuser = 0; s_tlast = 1; s_tdata = 25;
        repeat (3) begin
            @(negedge clk);
            chk("t_dis_tready", in_a.tready, 0);
        end
        @(posedge clk); #1;
        s_en = 1'b1;
        send(0, 1, 25);
        drain();
        chk("t_en_cost", cap_cost, 5);

        // Output back-pressure during EMIT_COST
        s_out_rdy = 1'b0;
        send(0, 0, 20);
        send(0, 1, 30);
        cycles_until_valid(n);
        repeat (10) begin
            @(negedge clk);
            chk("t3_stall_tvalid", out_a.tvalid, 1);
            chk("t3_stall_tdata", out_a.tdata, 0);
            chk("t3_stall_tlast", out_a.tlast, 0);
        end
        @(posedge clk); #1;
        s_out_rdy = 1'b1;
        drain();
        chk("t3_cost", cap_cost, 0);
        chk("t3_idx", cap_idx, 2);

        // Saturation with a single-sample reference
        send(1, 1, 0);
        chk("t4_ref_len", len_a, 1);
        send(0, 0, 65535);
        send(0, 1, 65535);
        drain();
        chk("t4_cost16", cap_cost_b, 65535);
        chk("t4_idx16", cap_idx_b, 0);
        chk("t4_cost32", cap_cost, 131070);
        chk("t4_idx32", cap_idx, 0);

        // Reference beat arriving mid-session is dropped
        load_ref4();
        send(0, 0, 20);
        send(1, 0, 99);
        send(0, 1, 30);
        drain();
        chk("t5_cost", cap_cost, 0);
        chk("t5_idx", cap_idx, 2);
        chk("t5_err", err_a, 1);
        chk("t5_ref_len", len_a, 4);

        // Reset in the middle of a row
        send(0, 0, 20);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        send(0, 1, 5);
        repeat (20) @(negedge clk);
        chk("t6_no_beat", out_a.tvalid, 0);
        chk("t6_err", err_a, 1);
        chk("t6_loaded", loaded_a, 0);
        chk("t6_busy", busy_a, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
